// File: rtl/led_scanner_ctrl_pkg.sv
// Shared types and constants for the LED scanner: motion modes and direction encoding.
package led_scan_pkg;

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'b00,
      MODE_WRAP_L = 2'b01,
      MODE_WRAP_R = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_t;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/led_scanner_ctrl_tick_divider.sv
// Step-rate divider: up-counter that fires a tick once every div_max+1 enabled cycles.
module tick_divider #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear,
   input  logic [DIV_W-1:0] div_max,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic             at_max;

   // >= rather than == so lowering div_max below cnt cannot strand the counter
   assign at_max = (cnt >= div_max);
   assign tick   = en & at_max;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= at_max ? '0 : cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/led_scanner_ctrl.sv
// N-wide one-hot LED scanner: position/direction state stepped by a divided tick, with load.
//
//   state (pos, dir)     | meaning
//   ---------------------+--------------------------------------------------
//   pos in 0..N-1        | lit LED index, out = 1 << pos
//   dir = DIR_LEFT  (1)  | bounce moves toward higher index
//   dir = DIR_RIGHT (0)  | bounce moves toward lower index
//   pos >= N (illegal)   | recovered to START/RIGHT on next tick or load
module led_scanner_ctrl
   import led_scan_pkg::*;
#(
   parameter  int N     = 8,
   parameter  int START = 2,
   parameter  int DIV_W = 24,
   localparam int PW    = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [DIV_W-1:0] div_max,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [PW-1:0]    load_pos,
   output logic [N-1:0]     out,
   output logic [PW-1:0]    pos,
   output logic             dir,
   output logic             step
);

   localparam int            PW1        = PW + 1;
   localparam logic [PW-1:0] POS_LAST   = PW'(N - 1);
   localparam logic [PW-1:0] POS_PENULT = PW'(N - 2);
   localparam logic [PW-1:0] POS_START  = PW'(START);
   localparam logic [PW:0]   LAST_EXT   = PW1'(N - 1);
   localparam logic [PW:0]   N_EXT      = PW1'(N);

   logic          tick;
   logic          pos_bad;
   logic [PW-1:0] load_clamped;
   logic [PW-1:0] pos_nxt;
   logic          dir_nxt;
   logic          step_nxt;
   mode_t         mode_sel;

   tick_divider #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .clear   (load),
      .div_max (div_max),
      .tick    (tick)
   );

   // Compares done one bit wider so they stay meaningful when N is a power of two
   assign pos_bad      = ({1'b0, pos} >= N_EXT);
   assign load_clamped = ({1'b0, load_pos} > LAST_EXT) ? POS_LAST : load_pos;
   assign mode_sel     = mode_t'(mode);

   always_ff @(posedge clk) begin
      if (reset) begin
         pos  <= POS_START;
         dir  <= DIR_RIGHT;
         step <= 1'b0;
      end else begin
         pos  <= pos_nxt;
         dir  <= dir_nxt;
         step <= step_nxt;
      end
   end

   always_comb begin
      pos_nxt  = pos;
      dir_nxt  = dir;
      step_nxt = 1'b0;
      if (load) begin
         if (pos_bad) begin
            pos_nxt = POS_START;
            dir_nxt = DIR_RIGHT;
         end else begin
            pos_nxt = load_clamped;
         end
      end else if (tick) begin
         step_nxt = 1'b1;
         if (pos_bad) begin
            pos_nxt = POS_START;
            dir_nxt = DIR_RIGHT;
         end else begin
            unique case (mode_sel)
               MODE_BOUNCE: begin
                  if (pos == POS_LAST) begin
                     pos_nxt = POS_PENULT;
                     dir_nxt = DIR_RIGHT;
                  end else if (pos == '0) begin
                     pos_nxt = PW'(1);
                     dir_nxt = DIR_LEFT;
                  end else if (dir == DIR_LEFT) begin
                     pos_nxt = pos + PW'(1);
                  end else begin
                     pos_nxt = pos - PW'(1);
                  end
               end
               MODE_WRAP_L: begin
                  pos_nxt = (pos == POS_LAST) ? '0 : pos + PW'(1);
                  dir_nxt = DIR_LEFT;
               end
               MODE_WRAP_R: begin
                  pos_nxt = (pos == '0) ? POS_LAST : pos - PW'(1);
                  dir_nxt = DIR_RIGHT;
               end
               MODE_HOLD: begin
                  pos_nxt = pos;
                  dir_nxt = dir;
               end
               default: begin
                  pos_nxt = pos;
                  dir_nxt = dir;
               end
            endcase
         end
      end
   end

   // A corrupted pos still lights exactly one LED rather than going dark
   assign out = pos_bad ? (N'(1) << START) : (N'(1) << pos);

endmodule

// File: tb/tb_led_scanner_ctrl.sv
// Self-checking bench for led_scanner_ctrl: N=8, N=5 and N=2 instances driven in lockstep.
module tb_led_scanner_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [23:0] div_max;
   logic [1:0]  mode;
   logic        load;
   logic [2:0]  load_pos;

   logic [7:0] out8;  logic [2:0] pos8; logic dir8; logic step8;
   logic [4:0] out5;  logic [2:0] pos5; logic dir5; logic step5;
   logic [1:0] out2;  logic [0:0] pos2; logic dir2; logic step2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int pos;
      int dir;
      int cnt;
      int step;
   } mdl_t;

   mdl_t m8 = '{0, 0, 0, 0};
   mdl_t m5 = '{0, 0, 0, 0};
   mdl_t m2 = '{0, 0, 0, 0};

   typedef struct {
      bit rst; bit e; int dm; int md; bit ld; int lp;
      int pos; int dir; int stp; int out;
   } vec_t;

   vec_t tbl[23];

   always #5 clk = ~clk;

   led_scanner_ctrl #(.N(8), .START(2)) dut8 (
      .clk(clk), .reset(reset), .en(en), .div_max(div_max), .mode(mode),
      .load(load), .load_pos(load_pos), .out(out8), .pos(pos8), .dir(dir8), .step(step8));

   led_scanner_ctrl #(.N(5), .START(2)) dut5 (
      .clk(clk), .reset(reset), .en(en), .div_max(div_max), .mode(mode),
      .load(load), .load_pos(load_pos), .out(out5), .pos(pos5), .dir(dir5), .step(step5));

   led_scanner_ctrl #(.N(2), .START(1)) dut2 (
      .clk(clk), .reset(reset), .en(en), .div_max(div_max), .mode(mode),
      .load(load), .load_pos(load_pos[0:0]), .out(out2), .pos(pos2), .dir(dir2), .step(step2));

   // Reference: one clock of the scanner described directly from its rules
   function automatic mdl_t model_next(mdl_t m, int n, int start, int lp,
                                       bit rst, bit e, int dm, int md, bit ld);
      mdl_t r = m;
      r.step = 0;
      if (rst) begin
         r.pos = start; r.dir = 0; r.cnt = 0;
      end else if (ld) begin
         r.pos = (lp > n - 1) ? n - 1 : lp;
         r.cnt = 0;
      end else if (e) begin
         if (r.cnt >= dm) begin
            r.cnt  = 0;
            r.step = 1;
            case (md)
               0: begin
                  if (r.pos == n - 1) begin
                     r.pos = n - 2; r.dir = 0;
                  end else if (r.pos == 0) begin
                     r.pos = 1; r.dir = 1;
                  end else begin
                     r.pos = r.dir ? r.pos + 1 : r.pos - 1;
                  end
               end
               1: begin r.pos = (r.pos + 1) % n;     r.dir = 1; end
               2: begin r.pos = (r.pos + n - 1) % n; r.dir = 0; end
               default: ;
            endcase
         end else begin
            r.cnt++;
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle_check();
      m8 = model_next(m8, 8, 2, int'(load_pos), reset, en, int'(div_max), int'(mode), load);
      m5 = model_next(m5, 5, 2, int'(load_pos), reset, en, int'(div_max), int'(mode), load);
      m2 = model_next(m2, 2, 1, int'(load_pos[0]), reset, en, int'(div_max), int'(mode), load);
      @(posedge clk);
      #1;
      check("n8 pos",  int'(pos8),  m8.pos);
      check("n8 dir",  int'(dir8),  m8.dir);
      check("n8 step", int'(step8), m8.step);
      check("n8 out",  int'(out8),  1 << m8.pos);
      check("n5 pos",  int'(pos5),  m5.pos);
      check("n5 dir",  int'(dir5),  m5.dir);
      check("n5 step", int'(step5), m5.step);
      check("n5 out",  int'(out5),  1 << m5.pos);
      check("n2 pos",  int'(pos2),  m2.pos);
      check("n2 dir",  int'(dir2),  m2.dir);
      check("n2 step", int'(step2), m2.step);
      check("n2 out",  int'(out2),  1 << m2.pos);
   endtask

   task automatic drive(input bit r, input bit e, input int dm, input int md,
                        input bit ld, input int lp);
      reset    = r;
      en       = e;
      div_max  = 24'(dm);
      mode     = 2'(md);
      load     = ld;
      load_pos = 3'(lp);
   endtask

   initial begin
      //            rst en dm md ld lp  pos dir stp out
      tbl[0]  = '{1, 1, 0, 0, 0, 0, 2, 0, 0, 'h04};
      tbl[1]  = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 'h02};
      tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 'h01};
      tbl[3]  = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 'h02};
      tbl[4]  = '{0, 1, 0, 0, 0, 0, 2, 1, 1, 'h04};
      tbl[5]  = '{0, 1, 0, 0, 0, 0, 3, 1, 1, 'h08};
      tbl[6]  = '{0, 1, 0, 0, 0, 0, 4, 1, 1, 'h10};
      tbl[7]  = '{0, 1, 0, 0, 0, 0, 5, 1, 1, 'h20};
      tbl[8]  = '{1, 1, 0, 0, 0, 0, 2, 0, 0, 'h04};
      tbl[9]  = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 'h02};
      tbl[10] = '{0, 1, 0, 0, 1, 6, 6, 0, 0, 'h40};
      tbl[11] = '{0, 1, 0, 0, 0, 0, 5, 0, 1, 'h20};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 'h20};
      tbl[13] = '{0, 0, 0, 0, 1, 3, 3, 0, 0, 'h08};
      tbl[14] = '{0, 1, 0, 1, 0, 0, 4, 1, 1, 'h10};
      tbl[15] = '{0, 1, 0, 3, 0, 0, 4, 1, 1, 'h10};
      tbl[16] = '{0, 1, 0, 0, 0, 0, 5, 1, 1, 'h20};
      tbl[17] = '{0, 1, 0, 2, 0, 0, 4, 0, 1, 'h10};
      tbl[18] = '{0, 1, 0, 1, 0, 0, 5, 1, 1, 'h20};
      tbl[19] = '{0, 1, 0, 0, 0, 0, 6, 1, 1, 'h40};
      tbl[20] = '{0, 1, 0, 0, 0, 0, 7, 1, 1, 'h80};
      tbl[21] = '{0, 1, 0, 0, 0, 0, 6, 0, 1, 'h40};
      tbl[22] = '{0, 1, 0, 0, 0, 0, 5, 0, 1, 'h20};

      drive(1, 0, 0, 0, 0, 0);

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].rst, tbl[i].e, tbl[i].dm, tbl[i].md, tbl[i].ld, tbl[i].lp);
         cycle_check();
         check($sformatf("vec%0d pos", i),  int'(pos8),  tbl[i].pos);
         check($sformatf("vec%0d dir", i),  int'(dir8),  tbl[i].dir);
         check($sformatf("vec%0d step", i), int'(step8), tbl[i].stp);
         check($sformatf("vec%0d out", i),  int'(out8),  tbl[i].out);
      end

      // Divider at div_max=3 with a 10-cycle pause mid-count
      drive(1, 1, 3, 0, 0, 0);
      cycle_check();
      drive(0, 1, 3, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle_check();
         check("div3 pre pos", int'(pos8), 2);
         check("div3 pre step", int'(step8), 0);
      end
      cycle_check();
      check("div3 tick pos", int'(pos8), 1);
      check("div3 tick step", int'(step8), 1);
      cycle_check();
      cycle_check();
      check("div3 count step", int'(step8), 0);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle_check();
         check("pause pos", int'(pos8), 1);
         check("pause step", int'(step8), 0);
      end
      en = 1'b1;
      cycle_check();
      check("resume pos", int'(pos8), 1);
      check("resume step", int'(step8), 0);
      cycle_check();
      check("resume tick pos", int'(pos8), 0);
      check("resume tick step", int'(step8), 1);

      // N=5 wrap-left then wrap-right from pos 3, then load clamp
      drive(0, 1, 0, 1, 1, 3);
      cycle_check();
      check("n5 load pos", int'(pos5), 3);
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle_check();
         check("n5 wrapl pos", int'(pos5), (i == 0) ? 4 : i - 1);
         check("n5 wrapl dir", int'(dir5), 1);
      end
      mode = 2'd2;
      for (int i = 0; i < 3; i++) begin
         cycle_check();
         check("n5 wrapr pos", int'(pos5), (i == 0) ? 0 : 5 - i);
         check("n5 wrapr dir", int'(dir5), 0);
      end
      drive(0, 1, 0, 2, 1, 7);
      cycle_check();
      check("n5 clamp pos", int'(pos5), 4);
      check("n8 load7 pos", int'(pos8), 7);
      check("load step", int'(step8), 0);

      // Hold at div_max=1, then back to bounce keeping LEFT
      drive(0, 1, 0, 1, 1, 3);
      cycle_check();
      drive(0, 1, 0, 1, 0, 0);
      cycle_check();
      check("pre-hold pos", int'(pos8), 4);
      check("pre-hold dir", int'(dir8), 1);
      drive(0, 1, 1, 3, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cycle_check();
         check("hold pos", int'(pos8), 4);
         check("hold step", int'(step8), i % 2);
      end
      drive(0, 1, 0, 0, 0, 0);
      cycle_check();
      check("unhold pos", int'(pos8), 5);
      check("unhold dir", int'(dir8), 1);

      // N=2 bounce
      drive(1, 1, 0, 0, 0, 0);
      cycle_check();
      check("n2 reset pos", int'(pos2), 1);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle_check();
         check("n2 bounce pos", int'(pos2), (i % 2 == 0) ? 0 : 1);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 63) == 0);
         en       = ($urandom_range(0, 3) != 0);
         div_max  = ($urandom_range(0, 15) == 0) ? 24'($urandom_range(4, 20))
                                                 : 24'($urandom_range(0, 3));
         mode     = 2'($urandom_range(0, 3));
         load     = ($urandom_range(0, 15) == 0);
         load_pos = 3'($urandom_range(0, 7));
         cycle_check();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
